// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard unit: forwarding encodings and the
// shadow-entry layout tracked for each downstream pipeline stage.
package hazard_unit_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] addr;
        logic                  is_load;
    } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one shadow entry against one ID source operand; fires only for a
// real producer (valid, writing, non-zero destination) of a source that is read.
module hazard_match
    import hazard_unit_pkg::*;
(
    input  logic                  valid,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  rd,
    output logic                  hit
);

    assign hit = valid & wr_en & (addr != '0) & rd & (addr == src);

endmodule

// File: rtl/hazard_unit.sv
// Load-use / RAW hazard detection with EX/MEM forwarding select.
// Define HAZARD_FORWARD_EN to enable bypassing; otherwise hazards are resolved by stalling.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             rs,
    input  logic [4:0]             rt,
    input  logic                   readRs,
    input  logic                   readRt,
    input  logic                   id_valid,
    input  logic                   id_wr_en,
    input  logic                   id_is_load,
    input  logic [4:0]             id_wr_addr,
    input  logic                   flush,
    output logic                   stall,
    output logic [1:0]             fwd_rs,
    output logic [1:0]             fwd_rt,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    entry_t     ex_q, mem_q, wb_q, id_ent;
    logic       ex_rs, ex_rt, mem_rs, mem_rt;
    logic       hazard, move;
    logic [1:0] fwd_rs_d, fwd_rt_d;
    logic       unused_fields;

    hazard_match u_ex_rs  (.valid(ex_q.valid),  .wr_en(ex_q.wr_en),  .addr(ex_q.addr),
                           .src(rs), .rd(readRs), .hit(ex_rs));
    hazard_match u_ex_rt  (.valid(ex_q.valid),  .wr_en(ex_q.wr_en),  .addr(ex_q.addr),
                           .src(rt), .rd(readRt), .hit(ex_rt));
    hazard_match u_mem_rs (.valid(mem_q.valid), .wr_en(mem_q.wr_en), .addr(mem_q.addr),
                           .src(rs), .rd(readRs), .hit(mem_rs));
    hazard_match u_mem_rt (.valid(mem_q.valid), .wr_en(mem_q.wr_en), .addr(mem_q.addr),
                           .src(rt), .rd(readRt), .hit(mem_rt));

`ifdef HAZARD_FORWARD_EN
    // Only a load in EX cannot be bypassed; ex wins over mem as the younger value.
    assign hazard   = ex_q.is_load & (ex_rs | ex_rt);
    assign fwd_rs_d = (ex_rs & ~ex_q.is_load) ? FWD_EX : (mem_rs ? FWD_MEM : FWD_REG);
    assign fwd_rt_d = (ex_rt & ~ex_q.is_load) ? FWD_EX : (mem_rt ? FWD_MEM : FWD_REG);
`else
    assign hazard   = ex_rs | ex_rt | mem_rs | mem_rt;
    assign fwd_rs_d = FWD_REG;
    assign fwd_rt_d = FWD_REG;
`endif

    assign stall  = id_valid & hazard;
    assign move   = id_valid & ~stall & ~flush;
    assign id_ent = '{valid: id_valid, wr_en: id_wr_en, addr: id_wr_addr, is_load: id_is_load};

    // wb needs no bypass (write-through regfile); these fields have no consumer here.
    assign unused_fields = ^{wb_q, mem_q.is_load, ex_q.is_load};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            fwd_rs    <= FWD_REG;
            fwd_rt    <= FWD_REG;
            stall_cnt <= '0;
        end else begin
            wb_q   <= mem_q;
            mem_q  <= ex_q;
            ex_q   <= move ? id_ent : '0;
            fwd_rs <= move ? fwd_rs_d : FWD_REG;
            fwd_rt <= move ? fwd_rt_d : FWD_REG;
            if (stall && !flush && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
